// File: rtl/aidc_lite_comp_sched.sv
// AIDC-Lite per-line compression sequencer.
// Streams one captured cache line to the encoder as sop/eop framed beats,
// gathers the concatenator's addressed word writes, then presents either the
// compressed payload or the raw line downstream. One line in flight at a time.
module aidc_lite_comp_sched #(
   parameter int NUM_WORDS     = 8,
   parameter int WORD_W        = 64,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        line_valid_i,
   output logic                        line_ready_o,
   input  logic [NUM_WORDS*WORD_W-1:0] line_data_i,
   output logic                        enc_valid_o,
   output logic                        enc_sop_o,
   output logic                        enc_eop_o,
   output logic [WORD_W-1:0]           enc_word_o,
   input  logic                        cat_valid_i,
   input  logic [2:0]                  cat_addr_i,
   input  logic [WORD_W-1:0]           cat_data_i,
   input  logic                        cat_done_i,
   input  logic                        cat_fail_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [NUM_WORDS*WORD_W-1:0] out_data_o,
   output logic                        out_comp_o,
   output logic [3:0]                  out_len_o,
   output logic                        busy_o
);

   localparam int LINE_W = NUM_WORDS * WORD_W;
   localparam int TW     = $clog2(DRAIN_TIMEOUT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FEED  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]        state;
   logic [LINE_W-1:0] line_buf;
   logic [LINE_W-1:0] res_buf;
   logic [3:0]        hwm;
   logic              armed;
   logic              fail_lat;
   logic [2:0]        beat_cnt;
   logic [TW-1:0]     to_cnt;

   logic [LINE_W-1:0] res_nxt;
   logic [3:0]        hwm_nxt;
   logic [3:0]        addr_p1;
   logic [2:0]        nxt_beat;
   logic              hard_fail;
   logic              drain_ok;
   logic              timed_out;
   logic              drain_exit;
   logic              use_comp;

   // Apply this cycle's concatenator write ahead of the drain decision so a
   // write coinciding with done still lands in the result.
   always_comb begin
      res_nxt  = res_buf;
      hwm_nxt  = hwm;
      addr_p1  = {1'b0, cat_addr_i} + 4'd1;
      nxt_beat = beat_cnt + 3'd1;
      if (cat_valid_i && (state == S_FEED || state == S_DRAIN)) begin
         res_nxt[cat_addr_i*WORD_W +: WORD_W] = cat_data_i;
         if (addr_p1 > hwm) hwm_nxt = addr_p1;
      end
      hard_fail  = fail_lat | cat_fail_i;
      drain_ok   = !hard_fail && armed && cat_done_i;
      timed_out  = (to_cnt == TW'(DRAIN_TIMEOUT - 1));
      drain_exit = hard_fail | drain_ok | timed_out;
      use_comp   = drain_ok && (hwm_nxt != 4'd0) && (hwm_nxt < 4'(NUM_WORDS));
   end

   // Line sequencing FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         line_buf     <= '0;
         res_buf      <= '0;
         hwm          <= '0;
         armed        <= 1'b0;
         fail_lat     <= 1'b0;
         beat_cnt     <= '0;
         to_cnt       <= '0;
         line_ready_o <= 1'b1;
         enc_valid_o  <= 1'b0;
         enc_sop_o    <= 1'b0;
         enc_eop_o    <= 1'b0;
         enc_word_o   <= '0;
         out_valid_o  <= 1'b0;
         out_data_o   <= '0;
         out_comp_o   <= 1'b0;
         out_len_o    <= '0;
         busy_o       <= 1'b0;
      end else begin
         res_buf <= res_nxt;
         hwm     <= hwm_nxt;
         case (state)
            S_IDLE: begin
               if (line_valid_i && line_ready_o) begin
                  line_buf     <= line_data_i;
                  res_buf      <= '0;
                  hwm          <= '0;
                  armed        <= 1'b0;
                  fail_lat     <= 1'b0;
                  beat_cnt     <= '0;
                  line_ready_o <= 1'b0;
                  busy_o       <= 1'b1;
                  enc_valid_o  <= 1'b1;
                  enc_sop_o    <= 1'b1;
                  enc_eop_o    <= 1'b0;
                  enc_word_o   <= line_data_i[WORD_W-1:0];
                  state        <= S_FEED;
               end
            end
            S_FEED: begin
               // A fail seen mid-feed is held so the encoder still gets eop.
               if (cat_fail_i) fail_lat <= 1'b1;
               if (!cat_done_i) armed <= 1'b1;
               if (beat_cnt == 3'(NUM_WORDS - 1)) begin
                  enc_valid_o <= 1'b0;
                  enc_sop_o   <= 1'b0;
                  enc_eop_o   <= 1'b0;
                  enc_word_o  <= '0;
                  to_cnt      <= '0;
                  state       <= S_DRAIN;
               end else begin
                  beat_cnt   <= nxt_beat;
                  enc_word_o <= line_buf[nxt_beat*WORD_W +: WORD_W];
                  enc_sop_o  <= 1'b0;
                  enc_eop_o  <= (nxt_beat == 3'(NUM_WORDS - 1));
               end
            end
            S_DRAIN: begin
               if (!cat_done_i) armed <= 1'b1;
               if (drain_exit) begin
                  out_valid_o <= 1'b1;
                  state       <= S_OUT;
                  if (use_comp) begin
                     out_comp_o <= 1'b1;
                     out_data_o <= res_nxt;
                     out_len_o  <= hwm_nxt;
                  end else begin
                     out_comp_o <= 1'b0;
                     out_data_o <= line_buf;
                     out_len_o  <= 4'(NUM_WORDS);
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  out_valid_o  <= 1'b0;
                  line_ready_o <= 1'b1;
                  busy_o       <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// Directed plus randomized bench for aidc_lite_comp_sched; expected results
// come from a word-array model of the result buffer and the decision rules.
module tb_aidc_lite_comp_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         line_valid_i;
   logic         line_ready_o;
   logic [511:0] line_data_i;
   logic         enc_valid_o;
   logic         enc_sop_o;
   logic         enc_eop_o;
   logic [63:0]  enc_word_o;
   logic         cat_valid_i;
   logic [2:0]   cat_addr_i;
   logic [63:0]  cat_data_i;
   logic         cat_done_i;
   logic         cat_fail_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [511:0] out_data_o;
   logic         out_comp_o;
   logic [3:0]   out_len_o;
   logic         busy_o;

   int checks   = 0;
   int failures = 0;

   logic [2:0]  wa [8];
   logic [63:0] wd [8];

   aidc_lite_comp_sched dut (
      .clk(clk), .rst(rst),
      .line_valid_i(line_valid_i), .line_ready_o(line_ready_o), .line_data_i(line_data_i),
      .enc_valid_o(enc_valid_o), .enc_sop_o(enc_sop_o), .enc_eop_o(enc_eop_o), .enc_word_o(enc_word_o),
      .cat_valid_i(cat_valid_i), .cat_addr_i(cat_addr_i), .cat_data_i(cat_data_i),
      .cat_done_i(cat_done_i), .cat_fail_i(cat_fail_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_comp_o(out_comp_o), .out_len_o(out_len_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rnd_line();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [63:0] rnd_word();
      return {$urandom, $urandom};
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_line_ready"}, line_ready_o, 1);
      chk({tag, "_enc_valid"}, enc_valid_o, 0);
      chk({tag, "_sop"}, enc_sop_o, 0);
      chk({tag, "_eop"}, enc_eop_o, 0);
      chk({tag, "_enc_word"}, enc_word_o, 0);
      chk({tag, "_out_valid"}, out_valid_o, 0);
      chk({tag, "_out_comp"}, out_comp_o, 0);
      chk({tag, "_out_data"}, out_data_o, 0);
      chk({tag, "_out_len"}, out_len_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   // mode 0: done goes high with the last write; mode 1: done held high (stale).
   // fail_beat >= 0 pulses cat_fail_i on that feed beat.
   task automatic do_line(input string tag, input logic [511:0] line, input int n_wr,
                          input int mode, input int fail_beat, input int rdy_delay);
      logic [63:0]  res [8];
      int           hwm;
      int           exp_cyc;
      int           cyc;
      logic [511:0] exp_data;
      logic         exp_comp;
      logic [3:0]   exp_len;
      bit           success;

      for (int i = 0; i < 8; i++) res[i] = '0;
      hwm = 0;
      if (fail_beat < 0) begin
         for (int i = 0; i < n_wr; i++) begin
            res[wa[i]] = wd[i];
            if (int'(wa[i]) + 1 > hwm) hwm = int'(wa[i]) + 1;
         end
      end
      success = (mode == 0) && (fail_beat < 0);
      if (success && hwm > 0 && hwm < 8) begin
         exp_comp = 1'b1;
         exp_len  = 4'(hwm);
         for (int i = 0; i < 8; i++) exp_data[64*i +: 64] = res[i];
      end else begin
         exp_comp = 1'b0;
         exp_len  = 4'd8;
         exp_data = line;
      end
      if (fail_beat >= 0)  exp_cyc = 1;
      else if (mode == 1)  exp_cyc = 16;
      else                 exp_cyc = (n_wr > 0) ? n_wr : 1;

      chk({tag, "_idle_ready"}, line_ready_o, 1);
      line_valid_i = 1'b1;
      line_data_i  = line;
      cat_done_i   = (mode == 1);
      cat_fail_i   = 1'b0;
      cat_valid_i  = 1'b0;
      step();
      line_valid_i = 1'b0;
      line_data_i  = rnd_line();

      for (int b = 0; b < 8; b++) begin
         chk({tag, "_beat_valid"}, enc_valid_o, 1);
         chk({tag, "_beat_sop"}, enc_sop_o, (b == 0));
         chk({tag, "_beat_eop"}, enc_eop_o, (b == 7));
         chk({tag, "_beat_word"}, enc_word_o, line[64*b +: 64]);
         chk({tag, "_beat_ready_low"}, line_ready_o, 0);
         cat_fail_i = (b == fail_beat);
         step();
      end
      cat_fail_i = 1'b0;
      chk({tag, "_feed_end"}, enc_valid_o, 0);

      cyc = 0;
      while (out_valid_o !== 1'b1 && cyc < 40) begin
         if (fail_beat < 0 && cyc < n_wr) begin
            cat_valid_i = 1'b1;
            cat_addr_i  = wa[cyc];
            cat_data_i  = wd[cyc];
         end else begin
            cat_valid_i = 1'b0;
         end
         cat_done_i = (mode == 1) ? 1'b1 : (cyc >= n_wr - 1);
         step();
         cyc++;
      end
      cat_valid_i = 1'b0;
      chk({tag, "_drain_cycles"}, cyc, exp_cyc);

      for (int d = 0; d <= rdy_delay; d++) begin
         chk({tag, "_out_valid"}, out_valid_o, 1);
         chk({tag, "_out_comp"}, out_comp_o, exp_comp);
         chk({tag, "_out_len"}, out_len_o, exp_len);
         chk({tag, "_out_data"}, out_data_o, exp_data);
         chk({tag, "_out_ready_low"}, line_ready_o, 0);
         chk({tag, "_out_busy"}, busy_o, 1);
         out_ready_i = (d == rdy_delay);
         cat_valid_i = (d < rdy_delay);
         cat_addr_i  = 3'($urandom_range(0, 7));
         cat_data_i  = rnd_word();
         step();
      end
      out_ready_i = 1'b0;
      cat_valid_i = 1'b0;
      chk({tag, "_post_valid"}, out_valid_o, 0);
      chk({tag, "_post_ready"}, line_ready_o, 1);
      chk({tag, "_post_busy"}, busy_o, 0);
   endtask

   initial begin
      logic [511:0] ln;
      int           n;
      int           r;

      rst = 1'b1; line_valid_i = 1'b0; line_data_i = '0;
      cat_valid_i = 1'b0; cat_addr_i = '0; cat_data_i = '0;
      cat_done_i = 1'b0; cat_fail_i = 1'b0; out_ready_i = 1'b0;
      step(); step();
      chk_reset("rst");
      rst = 1'b0;
      step();
      chk_reset("idle");

      // Compressed: three words then done.
      for (int i = 0; i < 3; i++) begin wa[i] = 3'(i); wd[i] = rnd_word(); end
      do_line("comp3", {8{64'h1111111111111111}}, 3, 0, -1, 0);

      // All eight words written: raw.
      for (int i = 0; i < 8; i++) begin wa[i] = 3'(7 - i); wd[i] = rnd_word(); end
      do_line("full8", rnd_line(), 8, 0, -1, 1);

      // Repeated address, last write wins.
      wa[0] = 3'd2; wa[1] = 3'd0; wa[2] = 3'd2;
      for (int i = 0; i < 3; i++) wd[i] = rnd_word();
      do_line("repeat", rnd_line(), 3, 0, -1, 0);

      // Done with no writes: hwm 0 gives raw.
      do_line("nowr", rnd_line(), 0, 0, -1, 0);

      // Fail pulse on feed beat 3.
      do_line("fail3", rnd_line(), 0, 0, 3, 0);

      // Done stuck high: timeout.
      wa[0] = 3'd0; wa[1] = 3'd1; wd[0] = rnd_word(); wd[1] = rnd_word();
      do_line("tmo", rnd_line(), 2, 1, -1, 0);

      // Downstream stall then immediate next line.
      for (int i = 0; i < 5; i++) begin wa[i] = 3'($urandom_range(0, 6)); wd[i] = rnd_word(); end
      do_line("stall", rnd_line(), 5, 0, -1, 5);
      for (int i = 0; i < 4; i++) begin wa[i] = 3'(i + 1); wd[i] = rnd_word(); end
      do_line("b2b", rnd_line(), 4, 0, -1, 0);

      // Reset during feed beat 4.
      ln = rnd_line();
      line_valid_i = 1'b1; line_data_i = ln; cat_done_i = 1'b0;
      step();
      line_valid_i = 1'b0;
      for (int b = 0; b < 4; b++) step();
      chk("abort_beat4", enc_word_o, ln[64*4 +: 64]);
      rst = 1'b1;
      step();
      chk_reset("abort");
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("abort_no_out", out_valid_o, 0);
         chk("abort_no_enc", enc_valid_o, 0);
      end

      // Randomized lines.
      for (int k = 0; k < 24; k++) begin
         n = $urandom_range(0, 8);
         for (int i = 0; i < 8; i++) begin
            wa[i] = 3'($urandom_range(0, 7));
            wd[i] = rnd_word();
         end
         r = $urandom_range(0, 9);
         if (r == 0)      do_line("rnd_tmo", rnd_line(), n, 1, -1, $urandom_range(0, 3));
         else if (r == 1) do_line("rnd_fail", rnd_line(), 0, 0, $urandom_range(0, 7), $urandom_range(0, 3));
         else             do_line("rnd", rnd_line(), n, 0, -1, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
